mul_host_seq: RTL and testbench



---
 rtl/mul_host_seq.sv | 121 ++++++++++++
 tb/tb_mul_host_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mul_host_seq.sv
// Host-side sequencer for an 8x8 -> 16-bit arithmetic core: drives an operand
// pair, waits a fixed latency, captures the result and streams it as two bytes.
module mul_host_seq #(
  parameter int unsigned LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  input  logic [7:0] res_lo,
  input  logic [7:0] res_hi,
  input  logic [7:0] res_oe,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy,
  output logic       err_oe
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRIVE   = 2'd1,
    SEND_LO = 2'd2,
    SEND_HI = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

  state_t      state_r;
  logic [3:0]  cnt_r;
  logic [15:0] result_r;
  logic [7:0]  op_a_r;
  logic [7:0]  op_b_r;
  logic        cmd_ready_r;
  logic        out_valid_r;
  logic        out_last_r;
  logic        busy_r;
  logic        err_oe_r;

  // Sequencer FSM with all handshake and status outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      result_r    <= 16'd0;
      op_a_r      <= 8'd0;
      op_b_r      <= 8'd0;
      cmd_ready_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
      err_oe_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            op_a_r      <= cmd_a;
            op_b_r      <= cmd_b;
            cnt_r       <= 4'd0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            state_r     <= DRIVE;
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_r == LAST_CNT) begin
            result_r    <= {res_hi, res_lo};
            // Flag a bus contention risk but still emit whatever was captured.
            if (res_oe != 8'hFF) begin
              err_oe_r <= 1'b1;
            end
            out_valid_r <= 1'b1;
            out_last_r  <= 1'b0;
            state_r     <= SEND_LO;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        SEND_LO: begin
          if (out_ready) begin
            out_last_r <= 1'b1;
            state_r    <= SEND_HI;
          end
        end
        SEND_HI: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          out_last_r  <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // Byte select is a mux of registers only, so it never depends on out_ready.
  assign out_data  = out_last_r ? result_r[15:8] : result_r[7:0];
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign cmd_ready = cmd_ready_r;
  assign op_a      = op_a_r;
  assign op_b      = op_b_r;
  assign busy      = busy_r;
  assign err_oe    = err_oe_r;

endmodule

// File: tb/tb_mul_host_seq.sv
// Directed bench for mul_host_seq with a behavioural two-cycle multiplier
// attached to the operand/result buses.
module tb_mul_host_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] res_lo;
  logic [7:0] res_hi;
  logic [7:0] res_oe;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;
  logic       err_oe;

  logic [15:0] prod_r = 16'd0;
  logic        oe_bad = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  mul_host_seq #(.LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b),
    .op_a(op_a), .op_b(op_b),
    .res_lo(res_lo), .res_hi(res_hi), .res_oe(res_oe),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .err_oe(err_oe)
  );

  always #5 clk = ~clk;

  // One register stage: a new product is visible at the second edge after op change.
  always @(posedge clk) prod_r <= 16'(op_a) * 16'(op_b);
  assign res_lo = prod_r[7:0];
  assign res_hi = prod_r[15:8];
  assign res_oe = oe_bad ? 8'h00 : 8'hFF;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a command until accepted; leaves cmd_valid high when hold is set.
  task automatic send_cmd(input logic [7:0] a, input logic [7:0] b, input bit hold);
    bit done = 0;
    cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
    for (int i = 0; i < 40 && !done; i++) begin
      done = cmd_ready;
      tick();
    end
    if (!hold) cmd_valid = 1'b0;
    if (!done) check("accept_timeout", 16'd0, 16'd1);
  endtask

  // Wait for the next beat, check it, then let it handshake.
  task automatic get_beat(input string tag, input logic [7:0] d, input logic l);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (out_valid && out_ready) seen = 1;
      else tick();
    end
    if (!seen) check({tag, "_timeout"}, 16'd0, 16'd1);
    else begin
      check({tag, "_data"}, 16'(out_data), 16'(d));
      check({tag, "_last"}, 16'(out_last), 16'(l));
      tick();
    end
  endtask

  initial begin
    int stray;
    rst = 1'b1; cmd_valid = 1'b0; cmd_a = 8'd0; cmd_b = 8'd0; out_ready = 1'b1;
    tick(); tick();
    check("rst_cmd_ready", 16'(cmd_ready), 16'd0);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_data",  16'(out_data),  16'd0);
    check("rst_op_a",      16'(op_a),      16'd0);
    check("rst_busy",      16'(busy),      16'd0);
    check("rst_err_oe",    16'(err_oe),    16'd0);
    rst = 1'b0;
    tick();
    check("post_rst_ready", 16'(cmd_ready), 16'd1);

    // 15*10 = 0x0096, valid two cycles after accept
    send_cmd(8'd15, 8'd10, 1'b0);
    check("t1_busy",  16'(busy), 16'd1);
    check("t1_op_a",  16'(op_a), 16'd15);
    check("t1_v0",    16'(out_valid), 16'd0);
    tick();
    check("t1_v1",    16'(out_valid), 16'd0);
    tick();
    check("t1_v2",    16'(out_valid), 16'd1);
    check("t1_lo",    16'(out_data),  16'h96);
    check("t1_lo_last", 16'(out_last), 16'd0);
    tick();
    check("t1_hi",    16'(out_data),  16'h00);
    check("t1_hi_last", 16'(out_last), 16'd1);
    check("t1_hi_valid", 16'(out_valid), 16'd1);
    tick();
    check("t1_done_valid", 16'(out_valid), 16'd0);
    check("t1_done_busy",  16'(busy), 16'd0);
    check("t1_err",        16'(err_oe), 16'd0);

    // 255*255 = 0xFE01
    send_cmd(8'd255, 8'd255, 1'b0);
    check("t2_busy", 16'(busy), 16'd1);
    get_beat("t2_b0", 8'h01, 1'b0);
    check("t2_busy_hi", 16'(busy), 16'd1);
    get_beat("t2_b1", 8'hFE, 1'b1);
    check("t2_busy_end", 16'(busy), 16'd0);

    // Backpressure with an ignored command during the stall; 16*16 = 0x0100
    out_ready = 1'b0;
    send_cmd(8'd16, 8'd16, 1'b0);
    tick(); tick();
    cmd_a = 8'd3; cmd_b = 8'd3; cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", 16'(out_valid), 16'd1);
      check("t3_hold_data",  16'(out_data),  16'h00);
      check("t3_hold_ready", 16'(cmd_ready), 16'd0);
      check("t3_hold_op_a",  16'(op_a),      16'd16);
      tick();
    end
    cmd_valid = 1'b0; out_ready = 1'b1;
    get_beat("t3_b0", 8'h00, 1'b0);
    get_beat("t3_b1", 8'h01, 1'b1);
    check("t3_op_a_end", 16'(op_a), 16'd16);

    // Back-to-back with cmd_valid held: 2*3 = 6, then 4*5 = 0x14
    send_cmd(8'd2, 8'd3, 1'b1);
    cmd_a = 8'd4; cmd_b = 8'd5;
    get_beat("t4_b0", 8'h06, 1'b0);
    get_beat("t4_b1", 8'h00, 1'b1);
    check("t4_ready_gap", 16'(cmd_ready), 16'd1);
    check("t4_op_a_gap",  16'(op_a),      16'd2);
    tick();
    cmd_valid = 1'b0;
    check("t4_second_busy", 16'(busy), 16'd1);
    check("t4_second_op_a", 16'(op_a), 16'd4);
    get_beat("t4_b2", 8'h14, 1'b0);
    get_beat("t4_b3", 8'h00, 1'b1);

    // Bad output enables: data still emitted, sticky error; 7*9 = 0x3F
    oe_bad = 1'b1;
    send_cmd(8'd7, 8'd9, 1'b0);
    get_beat("t5_b0", 8'h3F, 1'b0);
    check("t5_err", 16'(err_oe), 16'd1);
    get_beat("t5_b1", 8'h00, 1'b1);
    oe_bad = 1'b0;
    send_cmd(8'd1, 8'd1, 1'b0);
    get_beat("t5_b2", 8'h01, 1'b0);
    get_beat("t5_b3", 8'h00, 1'b1);
    check("t5_err_sticky", 16'(err_oe), 16'd1);

    // Reset mid-operation
    send_cmd(8'd100, 8'd3, 1'b0);
    tick();
    rst = 1'b1;
    #1;
    check("t6_busy",  16'(busy),      16'd0);
    check("t6_op_a",  16'(op_a),      16'd0);
    check("t6_valid", 16'(out_valid), 16'd0);
    check("t6_ready", 16'(cmd_ready), 16'd0);
    check("t6_err",   16'(err_oe),    16'd0);
    tick();
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) stray++;
    end
    check("t6_no_beat", 16'(stray), 16'd0);
    check("t6_idle_ready", 16'(cmd_ready), 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
